cic_agc_ctrl: RTL and testbench
===============================

CIC_AGC_CTRL -- requirements
Module: cic_agc_ctrl

Interface
REQ-001 SHALL have parameter GAIN_BITS, default 8, width of the gain code.
REQ-002 SHALL have parameter WINDOW, default 256, number of samples per peak measurement window.
REQ-003 SHALL have parameter SETTLE, default 4, number of samples ignored after each gain change.
REQ-004 SHALL have parameters HI_THRESH, default 24576, and LO_THRESH, default 8192, the peak magnitude thresholds.
REQ-005 SHALL have parameters GAIN_MIN, default 0; GAIN_MAX, default 255; GAIN_INIT, default 128.
REQ-006 SHALL have port CLK, input, 1 bit: single clock.
REQ-007 SHALL have port RSTb, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port in_tick, input, 1 bit: one-cycle strobe, driven by the CIC out_tick, marking x_in valid.
REQ-009 SHALL have port x_in, input, 16 bits signed: decimated CIC output sample.
REQ-010 SHALL have port agc_en, input, 1 bit: 1 selects automatic gain, 0 selects manual gain.
REQ-011 SHALL have port manual_gain, input, GAIN_BITS: gain code applied while agc_en=0.
REQ-012 SHALL have port gain, output reg, GAIN_BITS: gain code to the CIC gain input.
REQ-013 SHALL have port gain_update, output reg, 1 bit: one-cycle pulse whenever gain changes value.
REQ-014 SHALL have port peak, output reg, 16 bits unsigned: peak magnitude of the last completed window.
REQ-015 SHALL have port locked, output reg, 1 bit: high when the last decision made no change.

Function
REQ-016 SHALL implement states IDLE, MEASURE, DECIDE and HOLD.
REQ-017 SHALL remain in IDLE while agc_en=0, with gain following manual_gain on the next cycle.
REQ-018 SHALL go from IDLE to HOLD when agc_en rises, keeping the current gain, with the settle counter cleared.
REQ-019 SHALL, in any state, go to IDLE on the cycle after agc_en=0, abandoning the window and clearing the counters.
REQ-020 SHALL compute magnitude |x_in| with saturation: -32768 maps to 32767.
REQ-021 SHALL, in MEASURE, on each in_tick, update the running peak to max(running peak, magnitude) and increment the window counter.
REQ-022 SHALL enter DECIDE on the cycle after the in_tick that makes the window count equal WINDOW, and then wrap the window counter to 0.
REQ-023 SHALL, in DECIDE (exactly one cycle), copy the running peak to peak and clear the running peak.
REQ-024 SHALL, in DECIDE, apply this rule:
- peak > HI_THRESH and gain > GAIN_MIN: gain-1.
- peak < LO_THRESH and gain < GAIN_MAX: gain+1.
- otherwise: no change.
REQ-025 SHALL have gain saturate at GAIN_MIN and GAIN_MAX, never wrapping.
REQ-026 SHALL set locked=1 on a no-change decision and locked=0 on any change or in IDLE.
REQ-027 SHALL go from DECIDE to HOLD if gain changed, otherwise to MEASURE.
REQ-028 SHALL, in HOLD, count in_tick without measuring, and enter MEASURE after SETTLE ticks; SETTLE=0 SHALL enter MEASURE on the next cycle.
REQ-029 SHALL discard an in_tick coinciding with DECIDE (not counted, not measured).
REQ-030 SHALL assert gain_update for exactly one cycle, the cycle gain takes its new value, in both auto and manual mode; no pulse when the value is unchanged.
REQ-031 SHALL have a latency from the final window in_tick to the new gain value of 2 cycles.

Reset
REQ-032 SHALL, on RSTb=0 at a CLK edge, set state=IDLE, gain=GAIN_INIT, gain_update=0, peak=0, locked=0, and clear all counters and the running peak.
REQ-033 SHALL override all other inputs with reset, including mid-window; the first cycle after release SHALL follow REQ-017/REQ-018.

Configuration
REQ-034 SHALL, with macro CIC_AGC_FAST_ATTACK_EN defined, make a MEASURE in_tick with magnitude 32767 (clip) step gain down by 1 immediately (saturating), pulse gain_update, clear locked and the window, and enter HOLD.
REQ-035 SHALL, without CIC_AGC_FAST_ATTACK_EN, treat clipping only through the window decision of REQ-024.

Structure
REQ-036 SHALL take the state enumeration and the 16-bit magnitude width constant from shared package cic_pkg.
REQ-037 SHALL instantiate one sub-module, cic_agc_peak (saturating abs, running-max register, clear input).

Verification
REQ-038 SHALL cover window decision: agc_en=1, WINDOW=256, 256 ticks of constant x_in=30000 after settle -> peak=30000, gain 128->127, one gain_update pulse, 2 cycles after the last tick.
REQ-039 SHALL cover gain floor: gain at GAIN_MIN=0, x_in=-32768 windows -> peak=32767, gain stays 0, no gain_update, locked=1.
REQ-040 SHALL cover lock: x_in alternating +/-16000 -> locked=1, gain unchanged, state MEASURE to DECIDE to MEASURE with no HOLD.
REQ-041 SHALL cover the manual path: agc_en=0 mid-window with manual_gain=40 -> next cycle IDLE, gain=40, one gain_update pulse, window abandoned.
REQ-042 SHALL cover reset: RSTb=0 during HOLD -> gain=128, peak=0, locked=0, state IDLE.
REQ-043 SHALL cover fast attack, with CIC_AGC_FAST_ATTACK_EN: one x_in=32767 tick mid-window -> gain-1 the next cycle, state HOLD; without the macro -> no change until DECIDE.

Source files
------------

// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared state encoding, magnitude width and saturating abs for the CIC AGC
package cic_pkg;

  localparam int MAG_W = 16;
  localparam logic [MAG_W-1:0] MAG_MAX = {1'b0, {(MAG_W-1){1'b1}}};
  localparam logic [MAG_W-1:0] MAG_NEG = {1'b1, {(MAG_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DECIDE  = 2'd2,
    ST_HOLD    = 2'd3
  } agc_state_e;

  // The most negative code has no positive twin, so it clips to full scale.
  function automatic logic [MAG_W-1:0] sat_abs(input logic [MAG_W-1:0] x);
    if (x == MAG_NEG) return MAG_MAX;
    else if (x[MAG_W-1]) return ~x + MAG_W'(1);
    else return x;
  endfunction

endpackage

// File: rtl/cic_agc_peak.sv
// rtl/cic_agc_peak.sv - saturating |x| and running-max register; CIC_AGC_FAST_ATTACK_EN enables the clip flag
module cic_agc_peak
  import cic_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [MAG_W-1:0] x_i,
  output logic        [MAG_W-1:0] peak_o,
  output logic                    clip_o
);

  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] peak_q;

  always_comb mag = sat_abs(x_i);

  // Clear wins over a simultaneous update so a new window never inherits a sample.
  always_ff @(posedge clk_i) begin
    if (!rstn_i)                    peak_q <= '0;
    else if (clr_i)                 peak_q <= '0;
    else if (en_i && mag > peak_q)  peak_q <= mag;
  end

  assign peak_o = peak_q;

`ifdef CIC_AGC_FAST_ATTACK_EN
  assign clip_o = (mag == MAG_MAX);
`else
  assign clip_o = 1'b0;
`endif

endmodule

// File: rtl/cic_agc_ctrl.sv
// rtl/cic_agc_ctrl.sv - windowed-peak AGC for the CIC gain code; CIC_AGC_FAST_ATTACK_EN adds clip fast attack
module cic_agc_ctrl
  import cic_pkg::*;
#(
  parameter int GAIN_BITS = 8,
  parameter int WINDOW    = 256,
  parameter int SETTLE    = 4,
  parameter int HI_THRESH = 24576,
  parameter int LO_THRESH = 8192,
  parameter int GAIN_MIN  = 0,
  parameter int GAIN_MAX  = 255,
  parameter int GAIN_INIT = 128
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic                    in_tick,
  input  logic signed [MAG_W-1:0] x_in,
  input  logic                    agc_en,
  input  logic [GAIN_BITS-1:0]    manual_gain,
  output logic [GAIN_BITS-1:0]    gain,
  output logic                    gain_update,
  output logic [MAG_W-1:0]        peak,
  output logic                    locked
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [SET_W-1:0]     SET_LAST = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [GAIN_BITS-1:0] G_MIN    = GAIN_BITS'(GAIN_MIN);
  localparam logic [GAIN_BITS-1:0] G_MAX    = GAIN_BITS'(GAIN_MAX);
  localparam logic [GAIN_BITS-1:0] G_INIT   = GAIN_BITS'(GAIN_INIT);
  localparam logic [MAG_W-1:0]     HI       = MAG_W'(HI_THRESH);
  localparam logic [MAG_W-1:0]     LO       = MAG_W'(LO_THRESH);

  agc_state_e           state_q, state_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [SET_W-1:0]     set_q, set_d;
  logic [GAIN_BITS-1:0] gain_q, gain_d;
  logic                 upd_q, upd_d;
  logic [MAG_W-1:0]     peak_q, peak_d;
  logic                 locked_q, locked_d;

  logic                 pk_clr, pk_en, clip;
  logic [MAG_W-1:0]     run_peak;

  cic_agc_peak u_peak (
    .clk_i  (CLK),
    .rstn_i (RSTb),
    .clr_i  (pk_clr),
    .en_i   (pk_en),
    .x_i    (x_in),
    .peak_o (run_peak),
    .clip_o (clip)
  );

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    set_d    = set_q;
    gain_d   = gain_q;
    peak_d   = peak_q;
    locked_d = locked_q;
    pk_clr   = 1'b0;
    pk_en    = 1'b0;

    if (!agc_en) begin
      state_d  = ST_IDLE;
      win_d    = '0;
      set_d    = '0;
      gain_d   = manual_gain;
      locked_d = 1'b0;
      pk_clr   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_HOLD;
          win_d   = '0;
          set_d   = '0;
        end
        ST_HOLD: begin
          if (SETTLE == 0) begin
            state_d = ST_MEASURE;
          end else if (in_tick) begin
            if (set_q == SET_LAST) begin
              set_d   = '0;
              state_d = ST_MEASURE;
            end else begin
              set_d = set_q + SET_W'(1);
            end
          end
        end
        ST_MEASURE: begin
          if (in_tick) begin
            if (clip) begin
              if (gain_q > G_MIN) gain_d = gain_q - GAIN_BITS'(1);
              locked_d = 1'b0;
              win_d    = '0;
              set_d    = '0;
              pk_clr   = 1'b1;
              state_d  = ST_HOLD;
            end else begin
              pk_en = 1'b1;
              if (win_q == WIN_LAST) begin
                win_d   = '0;
                state_d = ST_DECIDE;
              end else begin
                win_d = win_q + WIN_W'(1);
              end
            end
          end
        end
        ST_DECIDE: begin
          // Ticks landing here are dropped: nothing counts or measures in this state.
          peak_d = run_peak;
          pk_clr = 1'b1;
          if (run_peak > HI && gain_q > G_MIN)      gain_d = gain_q - GAIN_BITS'(1);
          else if (run_peak < LO && gain_q < G_MAX) gain_d = gain_q + GAIN_BITS'(1);
          locked_d = (gain_d == gain_q);
          set_d    = '0;
          state_d  = (gain_d == gain_q) ? ST_MEASURE : ST_HOLD;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    upd_d = (gain_d != gain_q);
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      set_q    <= '0;
      gain_q   <= G_INIT;
      upd_q    <= 1'b0;
      peak_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      set_q    <= set_d;
      gain_q   <= gain_d;
      upd_q    <= upd_d;
      peak_q   <= peak_d;
      locked_q <= locked_d;
    end
  end

  assign gain        = gain_q;
  assign gain_update = upd_q;
  assign peak        = peak_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_cic_agc_ctrl.sv
// tb/tb_cic_agc_ctrl.sv - directed self-checking bench for cic_agc_ctrl (honours CIC_AGC_FAST_ATTACK_EN)
module tb_cic_agc_ctrl;
  import cic_pkg::*;

  logic               CLK = 1'b0;
  logic               RSTb;
  logic               in_tick;
  logic signed [15:0] x_in;
  logic               agc_en;
  logic [7:0]         manual_gain;
  logic [7:0]         gain;
  logic               gain_update;
  logic [15:0]        peak;
  logic               locked;

  int total = 0;
  int bad   = 0;

  cic_agc_ctrl dut (
    .CLK         (CLK),
    .RSTb        (RSTb),
    .in_tick     (in_tick),
    .x_in        (x_in),
    .agc_en      (agc_en),
    .manual_gain (manual_gain),
    .gain        (gain),
    .gain_update (gain_update),
    .peak        (peak),
    .locked      (locked)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] mg;
    logic [7:0] exp_gain;
    logic       exp_upd;
  } man_vec_t;

  typedef struct {
    logic signed [15:0] x;
    logic [15:0]        exp_mag;
  } mag_vec_t;

  man_vec_t man_tbl[8];
  mag_vec_t mag_tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic t, input logic signed [15:0] x);
    in_tick = t;
    x_in    = x;
    @(posedge CLK);
    #1;
    in_tick = 1'b0;
  endtask

  task automatic ticks(input int n, input logic signed [15:0] x, input bit alt);
    for (int i = 0; i < n; i++) step(1'b1, (alt && i[0]) ? -x : x);
  endtask

  task automatic chk_out(input string nm, input logic [7:0] g, input logic u, input logic l,
                         input agc_state_e s);
    chk({nm, ".gain"}, gain, g);
    chk({nm, ".upd"}, gain_update, u);
    chk({nm, ".locked"}, locked, l);
    chk({nm, ".state"}, dut.state_q, s);
  endtask

  initial begin
    man_tbl[0] = '{8'd128, 8'd128, 1'b0};
    man_tbl[1] = '{8'd40,  8'd40,  1'b1};
    man_tbl[2] = '{8'd40,  8'd40,  1'b0};
    man_tbl[3] = '{8'd41,  8'd41,  1'b1};
    man_tbl[4] = '{8'd255, 8'd255, 1'b1};
    man_tbl[5] = '{8'd0,   8'd0,   1'b1};
    man_tbl[6] = '{8'd0,   8'd0,   1'b0};
    man_tbl[7] = '{8'd128, 8'd128, 1'b1};

    mag_tbl[0] = '{16'sd0,      16'd0};
    mag_tbl[1] = '{16'sd1,      16'd1};
    mag_tbl[2] = '{-16'sd1,     16'd1};
    mag_tbl[3] = '{16'sd30000,  16'd30000};
    mag_tbl[4] = '{-16'sd30000, 16'd30000};
    mag_tbl[5] = '{16'sd32767,  16'd32767};
    mag_tbl[6] = '{-16'sd32768, 16'd32767};

    RSTb = 1'b0; in_tick = 1'b0; x_in = '0; agc_en = 1'b0; manual_gain = 8'd5;
    step(1'b0, 16'sd0);
    step(1'b1, 16'sd1000);
    chk("rst.gain", gain, 8'd128);
    chk("rst.peak", peak, 16'd0);
    chk("rst.locked", locked, 1'b0);
    chk("rst.upd", gain_update, 1'b0);
    chk("rst.state", dut.state_q, ST_IDLE);

    for (int i = 0; i < 7; i++) begin
      x_in = mag_tbl[i].x;
      #1;
      chk($sformatf("mag[%0d]", i), dut.u_peak.mag, mag_tbl[i].exp_mag);
    end

    RSTb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      manual_gain = man_tbl[i].mg;
      step(1'b0, 16'sd0);
      chk_out($sformatf("man[%0d]", i), man_tbl[i].exp_gain, man_tbl[i].exp_upd, 1'b0, ST_IDLE);
    end

    // Window decision: settle, 256 ticks of 30000, step down 2 cycles after the last tick.
    agc_en = 1'b1;
    step(1'b0, 16'sd0);
    chk("win.enter", dut.state_q, ST_HOLD);
    ticks(4, 16'sd0, 1'b0);
    chk("win.settled", dut.state_q, ST_MEASURE);
    ticks(255, 16'sd30000, 1'b0);
    chk_out("win.255", 8'd128, 1'b0, 1'b0, ST_MEASURE);
    step(1'b1, 16'sd30000);
    chk_out("win.lasttick", 8'd128, 1'b0, 1'b0, ST_DECIDE);
    step(1'b1, 16'sd32767);
    chk_out("win.decide", 8'd127, 1'b1, 1'b0, ST_HOLD);
    chk("win.peak", peak, 16'd30000);
    ticks(3, 16'sd0, 1'b0);
    chk("win.noupd", gain_update, 1'b0);
    chk("win.droptick", dut.state_q, ST_HOLD);
    step(1'b1, 16'sd0);
    chk("win.resettled", dut.state_q, ST_MEASURE);

    // Lock: mid-range alternating window leaves gain alone and skips HOLD.
    ticks(256, 16'sd16000, 1'b1);
    chk("lock.decide", dut.state_q, ST_DECIDE);
    step(1'b0, 16'sd0);
    chk_out("lock", 8'd127, 1'b0, 1'b1, ST_MEASURE);
    chk("lock.peak", peak, 16'd16000);

    // Manual override mid-window.
    ticks(10, 16'sd5000, 1'b0);
    agc_en = 1'b0; manual_gain = 8'd40;
    step(1'b1, 16'sd5000);
    chk_out("man.mid", 8'd40, 1'b1, 1'b0, ST_IDLE);
    chk("man.runpeak", dut.u_peak.peak_o, 16'd0);
    chk("man.win", dut.win_q, 0);
    step(1'b0, 16'sd0);
    chk("man.once", gain_update, 1'b0);

    // Gain floor with full-scale negative input.
    manual_gain = 8'd0;
    step(1'b0, 16'sd0);
    agc_en = 1'b1;
    step(1'b0, 16'sd0);
    ticks(4, 16'sd0, 1'b0);
`ifdef CIC_AGC_FAST_ATTACK_EN
    step(1'b1, -16'sd32768);
    chk_out("floor.fa", 8'd0, 1'b0, 1'b0, ST_HOLD);
`else
    ticks(256, -16'sd32768, 1'b0);
    step(1'b0, 16'sd0);
    chk_out("floor", 8'd0, 1'b0, 1'b1, ST_MEASURE);
    chk("floor.peak", peak, 16'd32767);
`endif

    // Ceiling: quiet input walks 254 -> 255, then holds there locked.
    agc_en = 1'b0; manual_gain = 8'd254;
    step(1'b0, 16'sd0);
    agc_en = 1'b1;
    step(1'b0, 16'sd0);
    ticks(4, 16'sd0, 1'b0);
    ticks(256, 16'sd100, 1'b1);
    step(1'b0, 16'sd0);
    chk_out("ceil.up", 8'd255, 1'b1, 1'b0, ST_HOLD);
    chk("ceil.peak", peak, 16'd100);
    ticks(4, 16'sd0, 1'b0);
    ticks(256, 16'sd0, 1'b0);
    step(1'b0, 16'sd0);
    chk_out("ceil.sat", 8'd255, 1'b0, 1'b1, ST_MEASURE);
    chk("ceil.peak0", peak, 16'd0);

    // Single clipping sample mid-window.
    ticks(5, 16'sd1000, 1'b0);
    step(1'b1, 16'sd32767);
`ifdef CIC_AGC_FAST_ATTACK_EN
    chk_out("fa", 8'd254, 1'b1, 1'b0, ST_HOLD);
`else
    chk_out("fa.off", 8'd255, 1'b0, 1'b1, ST_MEASURE);
`endif

    // Reset during HOLD overrides everything; release follows the manual path.
    agc_en = 1'b0; manual_gain = 8'd77;
    step(1'b0, 16'sd0);
    agc_en = 1'b1;
    step(1'b0, 16'sd0);
    step(1'b1, 16'sd0);
    chk("rsth.pre", dut.state_q, ST_HOLD);
    RSTb = 1'b0;
    step(1'b1, 16'sd32767);
    chk_out("rsth", 8'd128, 1'b0, 1'b0, ST_IDLE);
    chk("rsth.peak", peak, 16'd0);
    chk("rsth.set", dut.set_q, 0);
    RSTb = 1'b1; agc_en = 1'b0;
    step(1'b0, 16'sd0);
    chk_out("rsth.rel", 8'd77, 1'b1, 1'b0, ST_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
